rtc_alarm_mc: RTL and testbench

Multi-channel, parametrised successor to the always-on RTC counter/match block. It holds a free-running prescaled counter with `NCH` independent match channels. Each channel has a one-shot or auto-reload periodic mode, a W1C status bit and a mask bit. The block also captures the counter on an external event-trigger edge. It sits on the AON APB segment and drives one combined interrupt to the VIC and one match-event pulse to the ETB. The whole block runs on a single APB clock and has no separate RTC clock domain.

---
 rtl/rtc_alarm_mc_if.sv | 12 +
 rtl/rtc_alarm_mc.sv | 162 ++++++++++++++++
 tb/tb_rtc_alarm_mc.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_alarm_mc_if.sv
// APB bus bundle for rtc_alarm_mc; the requester drives control/data, the block returns prdata.
interface rtc_alarm_mc_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;

    modport master (output psel, penable, pwrite, paddr, pwdata, input prdata);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/rtc_alarm_mc.sv
// Prescaled free-running counter with NCH one-shot/periodic match channels,
// W1C status, interrupt masking, ETB match pulse and external-trigger capture.
module rtc_alarm_mc #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned DIV_W = 20
) (
    input  logic          i_pclk,
    input  logic          i_presetn,
    rtc_alarm_mc_if.slave apb,
    input  logic          i_etb_rtc_trig,
    input  logic          i_test_mode,
    output logic          o_rtc_intr,
    output logic          o_rtc_etb_trig
);
    localparam logic [5:0] A_CNT  = 6'h00;
    localparam logic [5:0] A_LOAD = 6'h01;
    localparam logic [5:0] A_CR   = 6'h02;
    localparam logic [5:0] A_DIV  = 6'h03;
    localparam logic [5:0] A_ISR  = 6'h04;
    localparam logic [5:0] A_IMR  = 6'h05;
    localparam logic [5:0] A_CAP  = 6'h06;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cap;
    logic [DIV_W-1:0] r_pre;
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_cr;
    logic [NCH-1:0]   r_isr;
    logic [NCH-1:0]   r_imr;
    logic [CNT_W-1:0] r_mr  [NCH];
    logic [CNT_W-1:0] r_per [NCH];
    logic             r_trig_d1;
    logic             r_trig_d2;
    logic             r_etb;

    logic [5:0]       w_idx;
    logic [2:0]       w_ch;
    logic             w_wr;
    logic             w_wr_load;
    logic             w_wr_div;
    logic             w_tick;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [NCH-1:0]   w_isr_clr;
    logic [NCH-1:0]   w_match;
    logic [NCH-1:0]   w_wr_mr;
    logic [NCH-1:0]   w_wr_per;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_idx     = apb.paddr[7:2];
    assign w_ch      = w_idx[2:0];
    assign w_wr      = apb.psel & apb.penable & apb.pwrite;
    assign w_wr_load = w_wr && (w_idx == A_LOAD);
    assign w_wr_div  = w_wr && (w_idx == A_DIV);
    assign w_isr_clr = (w_wr && (w_idx == A_ISR)) ? apb.pwdata[NCH-1:0] : '0;
    assign w_tick    = r_cr[0] & ((r_pre == r_div) | i_test_mode);
    assign w_unused  = ^{apb.paddr[31:8], apb.paddr[1:0], apb.pwdata};

    // A LOAD write replaces any increment; matches then compare against the loaded value.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_wr_load) begin
            w_cnt_nxt = apb.pwdata[CNT_W-1:0];
        end else if (w_tick) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_match  = '0;
        w_wr_mr  = '0;
        w_wr_per = '0;
        for (int i = 0; i < NCH; i++) begin
            w_match[i]  = w_tick && (w_cnt_nxt == r_mr[i]);
            w_wr_mr[i]  = w_wr && (w_idx[5:3] == 3'd1) && (w_ch == 3'(i));
            w_wr_per[i] = w_wr && (w_idx[5:3] == 3'd2) && (w_ch == 3'(i));
        end
    end

    always_comb begin
        w_rdata = '0;
        if (apb.psel && !apb.pwrite) begin
            case (w_idx)
                A_CNT:   w_rdata = 32'(r_cnt);
                A_CR:    w_rdata = 32'(r_cr);
                A_DIV:   w_rdata = 32'(r_div);
                A_ISR:   w_rdata = 32'(r_isr);
                A_IMR:   w_rdata = 32'(r_imr);
                A_CAP:   w_rdata = 32'(r_cap);
                default: begin
                    for (int i = 0; i < NCH; i++) begin
                        if (w_ch == 3'(i)) begin
                            if (w_idx[5:3] == 3'd1) begin
                                w_rdata = 32'(r_mr[i]);
                            end else if (w_idx[5:3] == 3'd2) begin
                                w_rdata = 32'(r_per[i]);
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            r_cnt     <= '0;
            r_cap     <= '0;
            r_pre     <= '0;
            r_div     <= '0;
            r_cr      <= '0;
            r_isr     <= '0;
            r_imr     <= '0;
            r_trig_d1 <= 1'b0;
            r_trig_d2 <= 1'b0;
            r_etb     <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                r_mr[i]  <= '0;
                r_per[i] <= '0;
            end
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_wr_load || w_wr_div || w_tick) begin
                r_pre <= '0;
            end else if (r_cr[0]) begin
                r_pre <= r_pre + 1'b1;
            end
            if (w_wr && (w_idx == A_CR)) begin
                r_cr <= apb.pwdata[2:0];
            end
            if (w_wr_div) begin
                r_div <= apb.pwdata[DIV_W-1:0];
            end
            if (w_wr && (w_idx == A_IMR)) begin
                r_imr <= apb.pwdata[NCH-1:0];
            end
            // Hardware set wins over a same-cycle W1C.
            r_isr <= (r_isr & ~w_isr_clr) | w_match;
            for (int i = 0; i < NCH; i++) begin
                if (w_match[i] && (r_per[i] != '0)) begin
                    r_mr[i] <= r_mr[i] + r_per[i];
                end else if (w_wr_mr[i]) begin
                    r_mr[i] <= apb.pwdata[CNT_W-1:0];
                end
                if (w_wr_per[i]) begin
                    r_per[i] <= apb.pwdata[CNT_W-1:0];
                end
            end
            r_etb     <= r_cr[2] & (|w_match);
            r_trig_d1 <= i_etb_rtc_trig;
            r_trig_d2 <= r_trig_d1;
            if (r_trig_d1 && !r_trig_d2 && r_cr[1]) begin
                r_cap <= r_cnt;
            end
        end
    end

    assign apb.prdata     = w_rdata;
    assign o_rtc_intr     = |(r_isr & ~r_imr);
    assign o_rtc_etb_trig = r_etb;
endmodule

// File: tb/tb_rtc_alarm_mc.sv
// Bench for rtc_alarm_mc: register table, directed timing sequences and
// randomized runs checked against a tick-level reference model.
module tb_rtc_alarm_mc;
    localparam int unsigned NCH   = 4;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned DIV_W = 20;

    localparam logic [31:0] A_CNT  = 32'h00;
    localparam logic [31:0] A_LOAD = 32'h04;
    localparam logic [31:0] A_CR   = 32'h08;
    localparam logic [31:0] A_DIV  = 32'h0C;
    localparam logic [31:0] A_ISR  = 32'h10;
    localparam logic [31:0] A_IMR  = 32'h14;
    localparam logic [31:0] A_CAP  = 32'h18;
    localparam logic [31:0] A_MR   = 32'h20;
    localparam logic [31:0] A_PER  = 32'h40;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic etb_in;
    logic test_mode;
    logic intr;
    logic etb_out;

    rtc_alarm_mc_if apb_bus ();

    rtc_alarm_mc #(.NCH(NCH), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
        .i_pclk         (clk),
        .i_presetn      (rst_n),
        .apb            (apb_bus),
        .i_etb_rtc_trig (etb_in),
        .i_test_mode    (test_mode),
        .o_rtc_intr     (intr),
        .o_rtc_etb_trig (etb_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int etb_q[$];
    always @(negedge clk) if (etb_out === 1'b1) etb_q.push_back(cyc);

    int n_total = 0;
    int n_bad = 0;
    int last_wr_cyc = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Both bus tasks are entered and left just after a falling edge.
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        apb_bus.psel    = 1'b1;
        apb_bus.pwrite  = 1'b1;
        apb_bus.penable = 1'b0;
        apb_bus.paddr   = addr;
        apb_bus.pwdata  = data;
        @(posedge clk);
        @(negedge clk);
        apb_bus.penable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        last_wr_cyc     = cyc;
        apb_bus.psel    = 1'b0;
        apb_bus.penable = 1'b0;
        apb_bus.pwrite  = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        apb_bus.psel    = 1'b1;
        apb_bus.pwrite  = 1'b0;
        apb_bus.penable = 1'b0;
        apb_bus.paddr   = addr;
        #1 data = apb_bus.prdata;
        @(posedge clk);
        @(negedge clk);
        apb_bus.penable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        apb_bus.psel    = 1'b0;
        apb_bus.penable = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        apb_read(addr, rd);
        check(name, rd, exp);
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
        if (cyc != target) begin
            n_total++;
            n_bad++;
            $display("FAIL sched: at cycle %0d required cycle %0d", cyc, target);
        end
    endtask

    // Move every channel far from the counter values a directed test visits.
    task automatic park();
        apb_write(A_CR, 32'h0);
        for (int i = 0; i < NCH; i++) begin
            apb_write(A_MR + 32'(4 * i), 32'h8000_0000);
            apb_write(A_PER + 32'(4 * i), 32'h0);
        end
        apb_write(A_IMR, 32'h0);
        apb_write(A_ISR, 32'hF);
    endtask

    task automatic run_trial(input int t);
        logic [31:0] start;
        logic [31:0] c;
        logic [31:0] mr [4];
        logic [31:0] per [4];
        logic [31:0] rd;
        logic [3:0]  imr;
        logic [3:0]  isr_m;
        logic        etben;
        logic        hit;
        int          div;
        int          n;
        int          e;
        int          ticks;
        int          pulses;
        div   = $urandom_range(0, 3);
        start = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFE0 + $urandom_range(0, 31) : $urandom;
        for (int i = 0; i < 4; i++) begin
            mr[i]  = start + $urandom_range(1, 30);
            per[i] = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom_range(1, 9);
        end
        if ($urandom_range(0, 1) == 1) mr[1] = mr[0];
        imr   = 4'($urandom_range(0, 15));
        etben = 1'($urandom_range(0, 1));
        n     = $urandom_range(10, 120);
        apb_write(A_DIV, 32'(div));
        for (int i = 0; i < 4; i++) begin
            apb_write(A_MR + 32'(4 * i), mr[i]);
            apb_write(A_PER + 32'(4 * i), per[i]);
        end
        apb_write(A_IMR, 32'(imr));
        apb_write(A_LOAD, start);
        apb_write(A_ISR, 32'hF);
        etb_q.delete();
        apb_write(A_CR, {29'b0, etben, 2'b01});
        e = last_wr_cyc;
        repeat (n) @(negedge clk);
        apb_write(A_CR, 32'h0);
        repeat (3) @(negedge clk);
        // Enabled edges run from the one after enable through the one that disables.
        ticks  = (last_wr_cyc - e) / (div + 1);
        c      = start;
        isr_m  = '0;
        pulses = 0;
        for (int k = 0; k < ticks; k++) begin
            c   = c + 1;
            hit = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (c == mr[i]) begin
                    isr_m[i] = 1'b1;
                    hit      = 1'b1;
                    mr[i]    = mr[i] + per[i];
                end
            end
            if (hit && etben) pulses++;
        end
        read_chk($sformatf("rnd%0d_cnt", t), A_CNT, c);
        for (int i = 0; i < 4; i++) begin
            read_chk($sformatf("rnd%0d_mr%0d", t, i), A_MR + 32'(4 * i), mr[i]);
        end
        apb_read(A_ISR, rd);
        check($sformatf("rnd%0d_isr", t), rd, 32'(isr_m));
        check($sformatf("rnd%0d_intr", t), 32'(intr), 32'(|(isr_m & ~imr)));
        check($sformatf("rnd%0d_etb_pulses", t), 32'(etb_q.size()), 32'(pulses));
    endtask

    vec_t vecs [17];

    initial begin
        int e;
        logic [31:0] rd;
        vecs[0]  = '{1'b1, A_DIV,       32'hFFFF_FFFF, 32'h000F_FFFF};
        vecs[1]  = '{1'b1, A_CR,        32'hFFFF_FFFE, 32'h0000_0006};
        vecs[2]  = '{1'b1, A_IMR,       32'h0000_00FF, 32'h0000_000F};
        vecs[3]  = '{1'b1, A_IMR,       32'h0000_0000, 32'h0000_0000};
        vecs[4]  = '{1'b1, A_MR,        32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 32'h2C,      32'h1234_5678, 32'h1234_5678};
        vecs[6]  = '{1'b1, 32'h48,      32'h0000_A5A5, 32'h0000_A5A5};
        vecs[7]  = '{1'b1, 32'h30,      32'h0000_0001, 32'h0000_0000};
        vecs[8]  = '{1'b1, 32'h5C,      32'h0000_0001, 32'h0000_0000};
        vecs[9]  = '{1'b1, 32'h1C,      32'hFFFF_FFFF, 32'h0000_0000};
        vecs[10] = '{1'b1, A_LOAD,      32'h0000_1234, 32'h0000_0000};
        vecs[11] = '{1'b0, A_CNT,       32'h0000_0000, 32'h0000_1234};
        vecs[12] = '{1'b1, A_CNT,       32'h0000_0099, 32'h0000_1234};
        vecs[13] = '{1'b1, A_ISR,       32'h0000_000F, 32'h0000_0000};
        vecs[14] = '{1'b1, A_CAP,       32'h0000_0005, 32'h0000_0000};
        vecs[15] = '{1'b1, 32'h60,      32'h0000_0001, 32'h0000_0000};
        vecs[16] = '{1'b1, A_CR,        32'h0000_0000, 32'h0000_0000};

        rst_n = 1'b0;
        etb_in = 1'b0;
        test_mode = 1'b0;
        apb_bus.psel = 1'b0;
        apb_bus.penable = 1'b0;
        apb_bus.pwrite = 1'b0;
        apb_bus.paddr = '0;
        apb_bus.pwdata = '0;
        repeat (3) @(negedge clk);
        check("rst_intr", 32'(intr), 32'h0);
        check("rst_etb", 32'(etb_out), 32'h0);
        check("rst_prdata", apb_bus.prdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        read_chk("rst_cnt", A_CNT, 32'h0);
        read_chk("rst_cr", A_CR, 32'h0);
        read_chk("rst_isr", A_ISR, 32'h0);
        read_chk("rst_mr0", A_MR, 32'h0);

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].wr) apb_write(vecs[i].addr, vecs[i].wdata);
            apb_read(vecs[i].addr, rd);
            check($sformatf("vec%0d", i), rd, vecs[i].exp);
        end

        // DIV=3: one tick every 4 enabled edges.
        park();
        apb_write(A_DIV, 32'd3);
        apb_write(A_LOAD, 32'd0);
        apb_write(A_CR, 32'd1);
        e = last_wr_cyc;
        wait_to(e + 19);
        read_chk("div3_cnt_e19", A_CNT, 32'd4);
        read_chk("div3_cnt_e21", A_CNT, 32'd5);
        wait_to(e + 24);
        read_chk("div3_cnt_e24", A_CNT, 32'd6);
        apb_write(A_CR, 32'd0);

        // DIV write mid-period restarts the prescaler.
        apb_write(A_LOAD, 32'd0);
        apb_write(A_CR, 32'd1);
        e = last_wr_cyc;
        wait_to(e + 4);
        apb_write(A_DIV, 32'd3);
        read_chk("divwr_cnt_e6", A_CNT, 32'd1);
        wait_to(e + 9);
        read_chk("divwr_cnt_e9", A_CNT, 32'd1);
        read_chk("divwr_cnt_e11", A_CNT, 32'd2);
        apb_write(A_CR, 32'd0);

        // One-shot match at 10, then W1C.
        park();
        apb_write(A_DIV, 32'd0);
        apb_write(A_LOAD, 32'd0);
        apb_write(A_MR, 32'd10);
        apb_write(A_CR, 32'd1);
        e = last_wr_cyc;
        wait_to(e + 9);
        check("oneshot_intr_pre", 32'(intr), 32'h0);
        @(negedge clk);
        check("oneshot_intr_hit", 32'(intr), 32'h1);
        check("oneshot_etb_off", 32'(etb_out), 32'h0);
        apb_write(A_CR, 32'd0);
        apb_write(A_ISR, 32'd1);
        check("oneshot_intr_w1c", 32'(intr), 32'h0);
        read_chk("oneshot_mr0", A_MR, 32'd10);
        read_chk("oneshot_isr", A_ISR, 32'd0);

        // Periodic channel 1: matches at 4, 9, 14.
        park();
        apb_write(A_LOAD, 32'd0);
        apb_write(A_MR + 32'h4, 32'd4);
        apb_write(A_PER + 32'h4, 32'd5);
        etb_q.delete();
        apb_write(A_CR, 32'd5);
        e = last_wr_cyc;
        wait_to(e + 15);
        apb_write(A_CR, 32'd0);
        repeat (2) @(negedge clk);
        check("per_etb_count", 32'(etb_q.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("per_etb_cyc%0d", k),
                  (k < etb_q.size()) ? 32'(etb_q[k] - e) : 32'hFFFF_FFFF, 32'(4 + 5 * k));
        end
        read_chk("per_mr1", A_MR + 32'h4, 32'd19);
        read_chk("per_isr", A_ISR, 32'd2);

        // Wrap: FE -> FF -> 0 matches channel 2.
        park();
        apb_write(A_DIV, 32'd3);
        apb_write(A_LOAD, 32'hFFFF_FFFE);
        apb_write(A_MR + 32'h8, 32'd0);
        apb_write(A_PER + 32'h8, 32'd3);
        apb_write(A_CR, 32'd1);
        e = last_wr_cyc;
        wait_to(e + 7);
        check("wrap_intr_pre", 32'(intr), 32'h0);
        read_chk("wrap_cnt_ff", A_CNT, 32'hFFFF_FFFF);
        check("wrap_intr_hit", 32'(intr), 32'h1);
        apb_write(A_CR, 32'd0);
        read_chk("wrap_cnt_0", A_CNT, 32'd0);
        read_chk("wrap_isr", A_ISR, 32'd4);
        read_chk("wrap_mr2", A_MR + 32'h8, 32'd3);

        // W1C in the match cycle loses to the hardware set.
        park();
        apb_write(A_DIV, 32'd0);
        apb_write(A_LOAD, 32'd0);
        apb_write(A_MR, 32'd10);
        apb_write(A_CR, 32'd1);
        e = last_wr_cyc;
        wait_to(e + 8);
        apb_write(A_ISR, 32'd1);
        check("coll_w1c_intr", 32'(intr), 32'h1);
        apb_write(A_CR, 32'd0);
        read_chk("coll_w1c_isr", A_ISR, 32'd1);

        // LOAD on a tick edge: no increment, match against loaded value.
        park();
        apb_write(A_DIV, 32'd3);
        apb_write(A_LOAD, 32'd0);
        apb_write(A_MR + 32'hC, 32'd100);
        apb_write(A_CR, 32'd1);
        e = last_wr_cyc;
        wait_to(e + 6);
        apb_write(A_LOAD, 32'd100);
        read_chk("coll_load_cnt", A_CNT, 32'd100);
        wait_to(e + 11);
        read_chk("coll_load_e11", A_CNT, 32'd100);
        read_chk("coll_load_e13", A_CNT, 32'd101);
        apb_write(A_CR, 32'd0);
        read_chk("coll_load_isr", A_ISR, 32'd8);

        // Test mode bypasses a large divider.
        park();
        apb_write(A_DIV, 32'd100);
        apb_write(A_LOAD, 32'd0);
        test_mode = 1'b1;
        apb_write(A_CR, 32'd1);
        e = last_wr_cyc;
        wait_to(e + 10);
        read_chk("tmode_cnt", A_CNT, 32'd10);
        apb_write(A_CR, 32'd0);
        test_mode = 1'b0;

        // Capture two edges after the trigger rises.
        apb_write(A_LOAD, 32'h55);
        apb_write(A_CR, 32'd2);
        apb_bus.psel   = 1'b1;
        apb_bus.pwrite = 1'b0;
        apb_bus.paddr  = A_CAP;
        etb_in = 1'b1;
        @(negedge clk);
        etb_in = 1'b0;
        #1 check("cap_edge1", apb_bus.prdata, 32'h0);
        @(negedge clk);
        #1 check("cap_edge2", apb_bus.prdata, 32'h55);
        @(negedge clk);
        apb_bus.psel = 1'b0;
        apb_write(A_LOAD, 32'h77);
        apb_write(A_CR, 32'd0);
        etb_in = 1'b1;
        @(negedge clk);
        etb_in = 1'b0;
        repeat (3) @(negedge clk);
        read_chk("cap_disabled", A_CAP, 32'h55);

        // Masked status holds the interrupt low.
        park();
        apb_write(A_DIV, 32'd0);
        apb_write(A_LOAD, 32'd0);
        apb_write(A_MR, 32'd3);
        apb_write(A_IMR, 32'd1);
        apb_write(A_CR, 32'd1);
        repeat (6) @(negedge clk);
        apb_write(A_CR, 32'd0);
        read_chk("mask_isr", A_ISR, 32'd1);
        check("mask_intr_low", 32'(intr), 32'h0);
        apb_write(A_IMR, 32'd0);
        check("mask_intr_unmasked", 32'(intr), 32'h1);

        for (int t = 0; t < 10; t++) run_trial(t);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
